// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> ACCESS -> RESP handshake to a word memory with ack timeout.
// Define MISALIGN_TRAP_EN to turn misaligned H/HU/W accesses into error responses instead of aligning them.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [15:0] LAST_CNT = 16'(ACK_TIMEOUT - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        req_ready_d, mem_req_d, mem_we_d, resp_valid_d, resp_err_d;
  logic [31:0] mem_addr_d, mem_wdata_d, resp_rdata_d;
  logic [3:0]  mem_wmask_d;

  logic        illegal;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode; low address bits beyond the access width are simply ignored
  always_comb begin
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_store;
      default:                illegal = 1'b1;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])        illegal = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) illegal = 1'b1;
`endif
  end

  always_comb begin
    lane_wdata = req_wdata;
    lane_mask  = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_mask  = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{req_wdata[15:0]}};
        lane_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load extraction from the acknowledged word using the latched width/offset
  always_comb begin
    ld_byte = 8'(mem_rdata >> {off_q, 3'b000});
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    store_d      = store_q;
    f3_d         = f3_q;
    off_d        = off_q;
    req_ready_d  = req_ready;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_wmask_d  = mem_wmask;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          store_d     = req_store;
          f3_d        = req_funct3;
          off_d       = req_addr[1:0];
          cnt_d       = '0;
          req_ready_d = 1'b0;
          if (illegal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_store;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_store ? lane_wdata : '0;
            mem_wmask_d = req_store ? lane_mask : 4'b0000;
          end
        end
      end
      ACCESS: begin
        if (mem_ack || cnt == LAST_CNT) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          mem_wmask_d  = 4'b0000;
          resp_valid_d = 1'b1;
          // ack wins over a simultaneous timeout
          resp_err_d   = !mem_ack;
          resp_rdata_d = (mem_ack && !store_q) ? ld_data : '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        cnt_d        = '0;
        req_ready_d  = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      store_q    <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      store_q    <= store_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      req_ready  <= req_ready_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_wmask  <= mem_wmask_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum number of ACCESS cycles to wait for mem_ack before an error response (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present from execute stage.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 SHALL have port req_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  effective address, taken from the ALU result (alu_c).
REQ-009 SHALL have port req_wdata  input  32  store data (rs2), LSB-aligned.
REQ-010 SHALL have port mem_req  output  1  memory access strobe, held until ack or timeout.
REQ-011 SHALL have port mem_we  output  1  write enable.
REQ-012 SHALL have port mem_addr  output  32  word address, {req_addr[31:2],2'b00}.
REQ-013 SHALL have port mem_wdata  output  32  store data shifted into byte lanes.
REQ-014 SHALL have port mem_wmask  output  4  byte-lane write mask; 0000 on loads.
REQ-015 SHALL have port mem_rdata  input  32  read word, valid with mem_ack.
REQ-016 SHALL have port mem_ack  input  1  single-cycle completion pulse from memory.
REQ-017 SHALL have port resp_valid  output  1  one-cycle response pulse to writeback.
REQ-018 SHALL have port resp_rdata  output  32  extended load result; 0 on stores and errors.
REQ-019 SHALL have port resp_err  output  1  response is an error (valid with resp_valid).

Function
REQ-020 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; all outputs registered.
REQ-021 SHALL, in IDLE with req_valid=1, latch req_* and move to ACCESS next cycle, asserting mem_req from the first ACCESS cycle.
REQ-022 SHALL hold mem_req, mem_we, mem_addr, mem_wdata and mem_wmask stable throughout ACCESS.
REQ-023 SHALL, on mem_ack in ACCESS, capture mem_rdata, deassert mem_req next cycle, enter RESP; minimum request-to-resp_valid latency is 3 cycles with zero-wait ack.
REQ-024 SHALL, for stores, set lane masks: SB 0001<<addr[1:0], SH 0011<<(2*addr[1]), SW 1111; wdata replicated or shifted into the selected lanes.
REQ-025 SHALL, for loads, select the byte/halfword by addr[1:0] and sign-extend (B, H) or zero-extend (BU, HU).
REQ-026 SHALL treat funct3 011, 110, 111 on any access, and 100/101 on stores, as illegal: no mem_req; go directly to RESP with resp_err=1.
REQ-027 SHALL count ACCESS cycles; if the count reaches ACK_TIMEOUT without mem_ack, drop mem_req and go to RESP with resp_err=1.
REQ-028 SHALL give mem_ack priority over timeout when both occur in the same cycle.
REQ-029 SHALL ignore mem_ack outside ACCESS and ignore req_valid outside IDLE.
REQ-030 SHALL assert resp_valid for exactly one cycle (RESP); RESP returns to IDLE unconditionally.

Reset
REQ-031 SHALL, when rst_n=0 at a clk edge, force IDLE, zero the timeout counter, and drive req_ready=1 and all other outputs to 0 from the next cycle.
REQ-032 SHALL abandon any in-flight access on reset with no response generated; a late mem_ack after reset is ignored.

Configuration
REQ-033 SHALL, with MISALIGN_TRAP_EN defined, treat H/HU with addr[0]=1 and W with addr[1:0]!=00 as misaligned: no mem_req; RESP with resp_err=1.
REQ-034 SHALL, without MISALIGN_TRAP_EN, silently clear the offending low address bits (H: bit 0; W: bits 1:0) and perform the access with resp_err=0.

Verification
REQ-035 SHALL cover LB at addr 0x103 with mem_rdata 0x80FF_1234, ack after 2 cycles -> resp_rdata 0xFFFF_FF80, resp_err 0.
REQ-036 SHALL cover SH at addr 0x202 with wdata 0x0000_BEEF -> mem_addr 0x200, mem_wmask 1100, mem_wdata[31:16] 0xBEEF, mem_we 1.
REQ-037 SHALL cover LW at 0x102: with MISALIGN_TRAP_EN -> no mem_req, resp_err 1; without -> mem_addr 0x100, resp_err 0.
REQ-038 SHALL cover ACK_TIMEOUT=4 with mem_ack never asserted -> mem_req high 4 cycles, then resp_valid with resp_err 1, resp_rdata 0.
REQ-039 SHALL cover rst_n=0 in ACCESS followed by mem_ack one cycle later -> no resp_valid, req_ready 1, mem_req 0.
REQ-040 SHALL cover a store with funct3 100 -> no mem_req, resp_valid with resp_err 1 two cycles after acceptance.
